// File: rtl/countdown_timer.sv
// countdown_timer: responder side of the controller's error-countdown handshake.
// While start_countdown is held high this block counts COUNT_SEC whole seconds,
// pulses tick on every second boundary and returns a one-cycle countdown_done
// pulse when the count reaches zero. Dropping the request early aborts silently.
// Optional feature macro: COUNTDOWN_SEG_EN adds the seg port, a registered
// two-digit active-low 7-segment view of the remaining seconds.

module countdown_timer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int COUNT_SEC = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_countdown,
    output logic        countdown_done,
    output logic [3:0]  remaining,
    output logic        active,
    output logic        tick
`ifdef COUNTDOWN_SEG_EN
    ,
    output logic [13:0] seg
`endif
);

    localparam int              PRE_W    = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [3:0]      SEC_LOAD = 4'(COUNT_SEC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PRE_W-1:0]  prescale_q;
    logic [3:0]        remain_q;
    logic              tick_q;
    logic              done_q;

    // Countdown FSM: prescaler, seconds counter and the registered pulses all
    // advance together so an abort on the final wrap suppresses tick and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            remain_q   <= 4'd0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    prescale_q <= '0;
                    remain_q   <= 4'd0;
                    if (start_countdown) begin
                        state_q  <= RUN;
                        remain_q <= SEC_LOAD;
                    end
                end
                RUN: begin
                    if (!start_countdown) begin
                        state_q    <= IDLE;
                        prescale_q <= '0;
                        remain_q   <= 4'd0;
                    end else if (prescale_q == PRE_MAX) begin
                        prescale_q <= '0;
                        tick_q     <= 1'b1;
                        if (remain_q <= 4'd1) begin
                            remain_q <= 4'd0;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            remain_q <= remain_q - 4'd1;
                        end
                    end else begin
                        prescale_q <= prescale_q + 1'b1;
                    end
                end
                DONE: begin
                    prescale_q <= '0;
                    remain_q   <= 4'd0;
                    if (!start_countdown) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    prescale_q <= '0;
                    remain_q   <= 4'd0;
                end
            endcase
        end
    end

    assign countdown_done = done_q;
    assign tick           = tick_q;
    assign remaining      = remain_q;
    assign active         = (state_q == RUN);

`ifdef COUNTDOWN_SEG_EN
    logic [13:0] seg_d;
    logic [13:0] seg_q;
    logic [3:0]  onesDigit;
    logic        tensIsOne;

    // Active-low {g,f,e,d,c,b,a} font for a single decimal digit.
    function automatic logic [6:0] segFont(input logic [3:0] digit);
        logic [6:0] litSegs;
        case (digit)
            4'd0:    litSegs = 7'h3F;
            4'd1:    litSegs = 7'h06;
            4'd2:    litSegs = 7'h5B;
            4'd3:    litSegs = 7'h4F;
            4'd4:    litSegs = 7'h66;
            4'd5:    litSegs = 7'h6D;
            4'd6:    litSegs = 7'h7D;
            4'd7:    litSegs = 7'h07;
            4'd8:    litSegs = 7'h7F;
            4'd9:    litSegs = 7'h6F;
            default: litSegs = 7'h00;
        endcase
        return ~litSegs;
    endfunction

    // Split remaining into tens/ones; the tens digit is blanked when zero and
    // the whole display is blanked outside RUN.
    always_comb begin
        tensIsOne = (remain_q >= 4'd10);
        onesDigit = tensIsOne ? (remain_q - 4'd10) : remain_q;
        seg_d     = 14'h3FFF;
        if (state_q == RUN) begin
            seg_d[13:7] = tensIsOne ? segFont(4'd1) : 7'h7F;
            seg_d[6:0]  = segFont(onesDigit);
        end
    end

    // Display register, trailing remaining by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 14'h3FFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with CLK_HZ=4 and
// COUNT_SEC=3. Expected outputs come from closed-form timing relative to the
// load edge and are queued when each edge is driven, then popped and compared
// one time unit after that edge.

module tb_countdown_timer;

    localparam int CLK_HZ    = 4;
    localparam int COUNT_SEC = 3;
    localparam int TOTAL     = CLK_HZ * COUNT_SEC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_countdown = 1'b0;
    logic       countdown_done;
    logic [3:0] remaining;
    logic       active;
    logic       tick;
`ifdef COUNTDOWN_SEG_EN
    logic [13:0] seg;
`endif

    typedef struct packed {
        logic       tick;
        logic       done;
        logic       act;
        logic [3:0] rem;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    countdown_timer #(
        .CLK_HZ   (CLK_HZ),
        .COUNT_SEC(COUNT_SEC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_countdown(start_countdown),
        .countdown_done (countdown_done),
        .remaining      (remaining),
        .active         (active),
        .tick           (tick)
`ifdef COUNTDOWN_SEG_EN
        ,
        .seg            (seg)
`endif
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the test sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    // Expected outputs after edge E0+n of a request held high since E0.
    function automatic exp_t runExp(input int n);
        exp_t e;
        e = '0;
        if (n < TOTAL) begin
            e.rem  = 4'(COUNT_SEC - n / CLK_HZ);
            e.act  = 1'b1;
            e.tick = (n > 0) && (n % CLK_HZ == 0);
        end else if (n == TOTAL) begin
            e.tick = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t quietExp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // Drive the request for the next edge, queue what must follow, and move to
    // the sampling point one time unit after that edge.
    task automatic driveEdge(input logic req, input exp_t e);
        start_countdown = req;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got, want;
        rst_n = 1'b0;
        start_countdown = 1'b0;
        #12;
        expQ.push_back(quietExp());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL reset_state got=%b want=%b", got, want);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            driveEdge(1'b0, quietExp());
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL reset_idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_full_count();
        exp_t got, want;
        for (int n = 0; n <= TOTAL + 3; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL full_count n=%0d got(tick,done,act,rem)=%b want=%b", n, got, want);
            end
        end
    endtask

    task automatic test_rearm();
        exp_t got, want;
        driveEdge(1'b0, quietExp());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL rearm_low got=%b want=%b", got, want);
        end
        for (int n = 0; n <= TOTAL + 1; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL rearm n=%0d got=%b want=%b", n, got, want);
            end
        end
        driveEdge(1'b0, quietExp());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL rearm_release got=%b want=%b", got, want);
        end
    endtask

    task automatic test_abort();
        exp_t got, want;
        for (int n = 0; n <= 6; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL abort_run n=%0d got=%b want=%b", n, got, want);
            end
        end
        for (int k = 0; k < TOTAL; k++) begin
            driveEdge(1'b0, quietExp());
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL abort_idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_race();
        exp_t got, want;
        for (int n = 0; n < TOTAL; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL race_run n=%0d got=%b want=%b", n, got, want);
            end
        end
        for (int k = 0; k < 3; k++) begin
            driveEdge(1'b0, quietExp());
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL race_final k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t got, want;
        for (int n = 0; n <= 5; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL midrun n=%0d got=%b want=%b", n, got, want);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        expQ.push_back(quietExp());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL async_reset got=%b want=%b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= TOTAL + 1; n++) begin
            driveEdge(1'b1, runExp(n));
            got  = {tick, countdown_done, active, remaining};
            want = expQ.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL post_reset n=%0d got=%b want=%b", n, got, want);
            end
        end
        driveEdge(1'b0, quietExp());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL post_reset_release got=%b want=%b", got, want);
        end
    endtask

`ifdef COUNTDOWN_SEG_EN
    task automatic test_seg();
        logic [13:0] wantSeg;
        logic [6:0]  threeLit;
        exp_t        got, want;
        threeLit = 7'h4F;
        vectors++;
        if (seg !== 14'h3FFF) begin
            miscompares++;
            $display("[TB] FAIL seg_idle got=%h want=3fff", seg);
        end
        driveEdge(1'b1, runExp(0));
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want || seg !== 14'h3FFF) begin
            miscompares++;
            $display("[TB] FAIL seg_load got=%b/%h want=%b/3fff", got, seg, want);
        end
        driveEdge(1'b1, runExp(1));
        wantSeg = {7'h7F, ~threeLit};
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want || seg !== wantSeg) begin
            miscompares++;
            $display("[TB] FAIL seg_digit got=%b/%h want=%b/%h", got, seg, want, wantSeg);
        end
        driveEdge(1'b0, quietExp());
        driveEdge(1'b0, quietExp());
        void'(expQ.pop_front());
        got  = {tick, countdown_done, active, remaining};
        want = expQ.pop_front();
        vectors++;
        if (got !== want || seg !== 14'h3FFF) begin
            miscompares++;
            $display("[TB] FAIL seg_blank got=%b/%h want=%b/3fff", got, seg, want);
        end
    endtask
`endif

    // Scenario sequence followed by the scoreboard drain check and summary.
    initial begin
        $display("[TB] countdown_timer bench start");
        test_reset();
        test_full_count();
        test_rearm();
        test_abort();
        test_race();
        test_reset_midrun();
`ifdef COUNTDOWN_SEG_EN
        test_seg();
`endif
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
